// File: rtl/axi_ram_ext_if.sv
// AXI4 channel bundle between a master and the axi_ram_ext slave memory.
// Master drives AW/W/AR and the B/R ready signals. Slave drives the remaining signals.
interface axi_ram_ext_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 4
);
  localparam int STRB = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB-1:0]       wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_ram_ext.sv
// AXI4 slave RAM with FIXED/INCR/WRAP bursts and a tohost exit mailbox. First rvalid comes READ_LATENCY cycles after AR.
// B and R are held stable until ready. One beat per cycle. Read and write channels run independently.
module axi_ram_ext #(
  parameter int          DATA_WIDTH     = 64,
  parameter int          ADDR_WIDTH     = 64,
  parameter int          ID_WIDTH       = 4,
  parameter int          MEM_ADDR_WIDTH = 18,
  parameter int          READ_LATENCY   = 1,
  parameter bit          TOHOST_EN      = 1'b1,
  parameter logic [63:0] TOHOST_ADDR    = 64'h0000_1000
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_ram_ext_if.slave          s_axi,
  output logic                  exit_valid,
  output logic [DATA_WIDTH-1:0] exit_code,
  output logic                  exit_pass
);
  localparam int STRB  = DATA_WIDTH / 8;
  localparam int SB    = $clog2(STRB);
  localparam int MAW   = MEM_ADDR_WIDTH;
  localparam int IW    = MAW - SB;
  localparam int DEPTH = 2 ** IW;
  localparam logic [1:0] B_FIXED = 2'b00, B_WRAP = 2'b10;
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;
  localparam logic [IW-1:0] TOHOST_IDX = TOHOST_ADDR[MAW-1:SB];

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  function automatic logic dec_err(input logic [7:0] len, input logic [2:0] size,
                                   input logic [1:0] burst);
    return (burst == 2'b11) || (size > 3'(SB)) ||
           ((burst == B_WRAP) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  endfunction

  // Arithmetic stays in the decoded address space, so upper address bits alias.
  function automatic logic [MAW-1:0] next_addr(input logic [MAW-1:0] addr, input logic [7:0] len,
                                               input logic [2:0] size, input logic [1:0] burst);
    logic [MAW-1:0] bytes, span_mask, incr;
    bytes     = MAW'(1) << size;
    span_mask = (bytes * (MAW'(len) + MAW'(1))) - MAW'(1);
    incr      = (addr & ~(bytes - MAW'(1))) + bytes;
    case (burst)
      B_FIXED: next_addr = addr;
      B_WRAP:  next_addr = (addr & ~span_mask) | (incr & span_mask);
      default: next_addr = incr;
    endcase
  endfunction

  // ---------------- write channel ----------------
  w_state_t            w_state, w_state_nxt;
  logic [ID_WIDTH-1:0] aw_id_q;
  logic [MAW-1:0]      aw_addr_q;
  logic [7:0]          aw_len_q, w_cnt_q;
  logic [2:0]          aw_size_q;
  logic [1:0]          aw_burst_q;
  logic                w_err_q, wlast_err_q;
  logic                aw_fire, w_fire, mbox_hit;
  logic [IW-1:0]       w_idx;

  assign aw_fire = s_axi.awvalid && s_axi.awready;
  assign w_fire  = s_axi.wvalid && s_axi.wready;
  assign w_idx   = aw_addr_q[MAW-1:SB];

  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (aw_fire) w_state_nxt = W_DATA;
      W_DATA:  if (w_fire && (w_cnt_q == aw_len_q)) w_state_nxt = W_RESP;
      W_RESP:  if (s_axi.bready) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    s_axi.awready = 1'b0;
    s_axi.wready  = 1'b0;
    s_axi.bvalid  = 1'b0;
    if (!rst) begin
      case (w_state)
        W_IDLE:  s_axi.awready = 1'b1;
        W_DATA:  s_axi.wready  = 1'b1;
        W_RESP:  s_axi.bvalid  = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_id_q     <= '0;
      aw_addr_q   <= '0;
      aw_len_q    <= '0;
      aw_size_q   <= '0;
      aw_burst_q  <= '0;
      w_cnt_q     <= '0;
      w_err_q     <= 1'b0;
      wlast_err_q <= 1'b0;
    end else begin
      if (aw_fire) begin
        aw_id_q     <= s_axi.awid;
        aw_addr_q   <= s_axi.awaddr[MAW-1:0];
        aw_len_q    <= s_axi.awlen;
        aw_size_q   <= s_axi.awsize;
        aw_burst_q  <= s_axi.awburst;
        w_cnt_q     <= '0;
        w_err_q     <= dec_err(s_axi.awlen, s_axi.awsize, s_axi.awburst);
        wlast_err_q <= 1'b0;
      end
      if (w_fire) begin
        aw_addr_q <= next_addr(aw_addr_q, aw_len_q, aw_size_q, aw_burst_q);
        w_cnt_q   <= w_cnt_q + 8'd1;
        if (s_axi.wlast && (w_cnt_q != aw_len_q)) wlast_err_q <= 1'b1;
      end
    end
  end

  assign s_axi.bid   = aw_id_q;
  assign s_axi.bresp = (w_err_q || wlast_err_q) ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge clk) begin
    if (w_fire && !w_err_q) begin
      for (int b = 0; b < STRB; b++) begin
        if (s_axi.wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
      end
    end
  end

  assign mbox_hit = TOHOST_EN && w_fire && !w_err_q && (w_idx == TOHOST_IDX) &&
                    (&s_axi.wstrb) && !exit_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      exit_valid <= 1'b0;
      exit_code  <= '0;
      exit_pass  <= 1'b0;
    end else if (mbox_hit) begin
      exit_valid <= 1'b1;
      exit_code  <= s_axi.wdata >> 1;
      exit_pass  <= (s_axi.wdata == DATA_WIDTH'(1));
    end
  end

  // ---------------- read channel ----------------
  r_state_t              r_state, r_state_nxt;
  logic [ID_WIDTH-1:0]   ar_id_q;
  logic [MAW-1:0]        ar_addr_q, rd_addr;
  logic [7:0]            ar_len_q, r_cnt_q;
  logic [2:0]            ar_size_q;
  logic [1:0]            ar_burst_q;
  logic [3:0]            lat_cnt_q;
  logic                  r_err_q, rd_err, rd_load;
  logic                  ar_fire, r_fire, last_beat;
  logic [DATA_WIDTH-1:0] rdata_q;

  assign ar_fire   = s_axi.arvalid && s_axi.arready;
  assign r_fire    = s_axi.rvalid && s_axi.rready;
  assign last_beat = (r_cnt_q == ar_len_q);

  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_fire) r_state_nxt = (READ_LATENCY == 1) ? R_DATA : R_WAIT;
      R_WAIT:  if (lat_cnt_q == 4'd0) r_state_nxt = R_DATA;
      R_DATA:  if (r_fire && last_beat) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi.arready = 1'b0;
    s_axi.rvalid  = 1'b0;
    if (!rst) begin
      case (r_state)
        R_IDLE:  s_axi.arready = 1'b1;
        R_DATA:  s_axi.rvalid  = 1'b1;
        default: ;
      endcase
    end
  end

  // The data register is loaded one cycle before each beat is presented.
  always_comb begin
    rd_load = 1'b0;
    rd_addr = ar_addr_q;
    rd_err  = r_err_q;
    case (r_state)
      R_IDLE: if (ar_fire && (READ_LATENCY == 1)) begin
        rd_load = 1'b1;
        rd_addr = s_axi.araddr[MAW-1:0];
        rd_err  = dec_err(s_axi.arlen, s_axi.arsize, s_axi.arburst);
      end
      R_WAIT: rd_load = (lat_cnt_q == 4'd0);
      R_DATA: if (r_fire && !last_beat) begin
        rd_load = 1'b1;
        rd_addr = next_addr(ar_addr_q, ar_len_q, ar_size_q, ar_burst_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      r_cnt_q    <= '0;
      lat_cnt_q  <= '0;
      r_err_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (ar_fire) begin
        ar_id_q    <= s_axi.arid;
        ar_addr_q  <= s_axi.araddr[MAW-1:0];
        ar_len_q   <= s_axi.arlen;
        ar_size_q  <= s_axi.arsize;
        ar_burst_q <= s_axi.arburst;
        r_cnt_q    <= '0;
        lat_cnt_q  <= 4'(READ_LATENCY - 2);
        r_err_q    <= dec_err(s_axi.arlen, s_axi.arsize, s_axi.arburst);
      end
      if ((r_state == R_WAIT) && (lat_cnt_q != 4'd0)) lat_cnt_q <= lat_cnt_q - 4'd1;
      if (r_fire) begin
        ar_addr_q <= rd_addr;
        r_cnt_q   <= r_cnt_q + 8'd1;
      end
      if (rd_load) rdata_q <= rd_err ? '0 : mem[rd_addr[MAW-1:SB]];
    end
  end

  assign s_axi.rid   = ar_id_q;
  assign s_axi.rdata = rdata_q;
  assign s_axi.rresp = r_err_q ? RESP_SLVERR : RESP_OKAY;
  assign s_axi.rlast = s_axi.rvalid && last_beat;

  logic unused_ok;
  assign unused_ok = ^{s_axi.awaddr[ADDR_WIDTH-1:MAW], s_axi.araddr[ADDR_WIDTH-1:MAW],
                       s_axi.awlock, s_axi.awcache, s_axi.awprot,
                       s_axi.arlock, s_axi.arcache, s_axi.arprot};
endmodule

// File: tb/tb_axi_ram_ext.sv
// Directed bench for axi_ram_ext: one instance with READ_LATENCY=1, one with READ_LATENCY=4, sharing write traffic.
module tb_axi_ram_ext;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0]  awid = '0, arid = '0;
  logic [63:0] awaddr = '0, araddr = '0, wdata = '0;
  logic [7:0]  awlen = '0, arlen = '0, wstrb = '0;
  logic [2:0]  awsize = '0, arsize = '0;
  logic [1:0]  awburst = '0, arburst = '0;
  logic        awvalid = 1'b0, wlast = 1'b0, wvalid = 1'b0, bready = 1'b1;
  logic        arvalid = 1'b0, rready = 1'b0, sel = 1'b0;
  logic [63:0] exp_q [16];

  axi_ram_ext_if #(.DATA_WIDTH(64), .ADDR_WIDTH(64), .ID_WIDTH(4)) if1 ();
  axi_ram_ext_if #(.DATA_WIDTH(64), .ADDR_WIDTH(64), .ID_WIDTH(4)) if4 ();

  assign if1.awid = awid;       assign if4.awid = awid;
  assign if1.awaddr = awaddr;   assign if4.awaddr = awaddr;
  assign if1.awlen = awlen;     assign if4.awlen = awlen;
  assign if1.awsize = awsize;   assign if4.awsize = awsize;
  assign if1.awburst = awburst; assign if4.awburst = awburst;
  assign if1.awlock = 1'b0;     assign if4.awlock = 1'b0;
  assign if1.awcache = 4'h0;    assign if4.awcache = 4'h0;
  assign if1.awprot = 3'h0;     assign if4.awprot = 3'h0;
  assign if1.awvalid = awvalid; assign if4.awvalid = awvalid;
  assign if1.wdata = wdata;     assign if4.wdata = wdata;
  assign if1.wstrb = wstrb;     assign if4.wstrb = wstrb;
  assign if1.wlast = wlast;     assign if4.wlast = wlast;
  assign if1.wvalid = wvalid;   assign if4.wvalid = wvalid;
  assign if1.bready = bready;   assign if4.bready = bready;
  assign if1.arid = arid;       assign if4.arid = arid;
  assign if1.araddr = araddr;   assign if4.araddr = araddr;
  assign if1.arlen = arlen;     assign if4.arlen = arlen;
  assign if1.arsize = arsize;   assign if4.arsize = arsize;
  assign if1.arburst = arburst; assign if4.arburst = arburst;
  assign if1.arlock = 1'b0;     assign if4.arlock = 1'b0;
  assign if1.arcache = 4'h0;    assign if4.arcache = 4'h0;
  assign if1.arprot = 3'h0;     assign if4.arprot = 3'h0;
  assign if1.arvalid = arvalid & ~sel;
  assign if4.arvalid = arvalid & sel;
  assign if1.rready = rready & ~sel;
  assign if4.rready = rready & sel;

  logic        arready_s, rvalid_s, rlast_s;
  logic [63:0] rdata_s;
  logic [1:0]  rresp_s;
  logic [3:0]  rid_s;
  assign arready_s = sel ? if4.arready : if1.arready;
  assign rvalid_s  = sel ? if4.rvalid  : if1.rvalid;
  assign rlast_s   = sel ? if4.rlast   : if1.rlast;
  assign rdata_s   = sel ? if4.rdata   : if1.rdata;
  assign rresp_s   = sel ? if4.rresp   : if1.rresp;
  assign rid_s     = sel ? if4.rid     : if1.rid;

  logic        ev1, ep1, ev4, ep4;
  logic [63:0] ec1, ec4;

  axi_ram_ext #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .s_axi(if1), .exit_valid(ev1), .exit_code(ec1), .exit_pass(ep1));
  axi_ram_ext #(.READ_LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .s_axi(if4), .exit_valid(ev4), .exit_code(ec4), .exit_pass(ep4));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full write burst; beat i carries base+i. early puts wlast on every beat.
  task automatic wr(input string tag, input logic [63:0] addr, input logic [7:0] len,
                    input logic [2:0] size, input logic [1:0] burst, input logic [63:0] base,
                    input logic [7:0] strb, input logic early, input logic [1:0] exp_resp);
    int n;
    awid = 4'h3; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!if1.awready && n < 50) begin tick(); n++; end
    chk({tag, "_awready"}, if1.awready, 1);
    tick();
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = base + 64'(i); wstrb = strb; wlast = early || (i == int'(len)); wvalid = 1'b1;
      n = 0;
      while (!if1.wready && n < 50) begin tick(); n++; end
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk({tag, "_bvalid"}, if1.bvalid, 1);
    chk({tag, "_bresp"}, if1.bresp, exp_resp);
    chk({tag, "_bid"}, if1.bid, 4'h3);
    tick();
    chk({tag, "_awready_back"}, if1.awready, 1);
  endtask

  // Read burst against exp_q; stall inserts one rready=0 cycle before each odd beat.
  task automatic rd(input string tag, input logic s, input logic [63:0] addr, input logic [7:0] len,
                    input logic [2:0] size, input logic [1:0] burst, input logic stall,
                    input int lat, input logic [1:0] exp_resp);
    int n;
    sel = s; arid = 4'h5; araddr = addr; arlen = len; arsize = size; arburst = burst;
    arvalid = 1'b1;
    #1;
    n = 0;
    while (!arready_s && n < 50) begin tick(); n++; end
    tick();
    arvalid = 1'b0;
    n = 1;
    while (!rvalid_s && n < 50) begin tick(); n++; end
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    for (int b = 0; b <= int'(len); b++) begin
      if (stall && b[0]) begin
        rready = 1'b0;
        chk({tag, "_pre_stall_data"}, rdata_s, exp_q[b]);
        tick();
        chk({tag, "_stall_valid"}, rvalid_s, 1);
      end
      chk({tag, "_rvalid"}, rvalid_s, 1);
      chk({tag, "_rdata"}, rdata_s, exp_q[b]);
      chk({tag, "_rlast"}, rlast_s, (b == int'(len)));
      chk({tag, "_rresp"}, rresp_s, exp_resp);
      chk({tag, "_rid"}, rid_s, 4'h5);
      rready = 1'b1;
      tick();
      rready = 1'b0;
    end
    chk({tag, "_rvalid_end"}, rvalid_s, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk("rst_awready", if1.awready, 0);
    chk("rst_arready", if1.arready, 0);
    chk("rst_bvalid", if1.bvalid, 0);
    chk("rst_rvalid", if1.rvalid, 0);
    chk("rst_exit", ev1, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_awready", if1.awready, 1);

    // single beat write and readback
    wr("w40", 64'h40, 8'd0, 3'd3, 2'b01, 64'h1122_3344_5566_7788, 8'hFF, 1'b0, 2'b00);
    exp_q[0] = 64'h1122_3344_5566_7788;
    rd("r40", 1'b0, 64'h40, 8'd0, 3'd3, 2'b01, 1'b0, 1, 2'b00);

    // INCR fill of 0x100..0x118, then latency-4 read with stalls
    wr("w100", 64'h100, 8'd3, 3'd3, 2'b01, 64'h5000, 8'hFF, 1'b0, 2'b00);
    exp_q[0] = 64'h5000; exp_q[1] = 64'h5001; exp_q[2] = 64'h5002; exp_q[3] = 64'h5003;
    rd("r100_lat4", 1'b1, 64'h100, 8'd3, 3'd3, 2'b01, 1'b1, 4, 2'b00);

    // WRAP: 0x110, 0x118, 0x100, 0x108
    exp_q[0] = 64'h5002; exp_q[1] = 64'h5003; exp_q[2] = 64'h5000; exp_q[3] = 64'h5001;
    rd("wrap4", 1'b0, 64'h110, 8'd3, 3'd3, 2'b10, 1'b0, 1, 2'b00);
    exp_q[0] = 64'h0; exp_q[1] = 64'h0; exp_q[2] = 64'h0;
    rd("wrap_len2", 1'b0, 64'h110, 8'd2, 3'd3, 2'b10, 1'b0, 1, 2'b10);

    // byte strobes over a zeroed word
    wr("w0_clr", 64'h0, 8'd0, 3'd3, 2'b01, 64'h0, 8'hFF, 1'b0, 2'b00);
    wr("w0_strb", 64'h0, 8'd0, 3'd3, 2'b01, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, 1'b0, 2'b00);
    exp_q[0] = 64'h0000_0000_BBBB_BBBB;
    rd("r0_strb", 1'b0, 64'h0, 8'd0, 3'd3, 2'b01, 1'b0, 1, 2'b00);

    // FIXED burst leaves only the last beat and does not touch the next word
    wr("w308", 64'h308, 8'd0, 3'd3, 2'b01, 64'hDEAD, 8'hFF, 1'b0, 2'b00);
    wr("w300_fixed", 64'h300, 8'd3, 3'd3, 2'b00, 64'h6000, 8'hFF, 1'b0, 2'b00);
    exp_q[0] = 64'h6003; exp_q[1] = 64'hDEAD;
    rd("r300", 1'b0, 64'h300, 8'd1, 3'd3, 2'b01, 1'b0, 1, 2'b00);

    // reserved burst type: error, no write
    wr("w40_bad_burst", 64'h40, 8'd0, 3'd3, 2'b11, 64'hFFFF, 8'hFF, 1'b0, 2'b10);
    exp_q[0] = 64'h1122_3344_5566_7788;
    rd("r40_kept", 1'b0, 64'h40, 8'd0, 3'd3, 2'b01, 1'b0, 1, 2'b00);

    // early wlast: error but data still written by beat count
    wr("w400_early", 64'h400, 8'd1, 3'd3, 2'b01, 64'h8000, 8'hFF, 1'b1, 2'b10);
    exp_q[0] = 64'h8000; exp_q[1] = 64'h8001;
    rd("r400", 1'b0, 64'h400, 8'd1, 3'd3, 2'b01, 1'b0, 1, 2'b00);

    // oversize read
    exp_q[0] = 64'h0;
    rd("r40_size4", 1'b0, 64'h40, 8'd0, 3'd4, 2'b01, 1'b0, 1, 2'b10);

    // mailbox: pass, then ignored rewrite
    wr("mbox1", 64'h1000, 8'd0, 3'd3, 2'b01, 64'h1, 8'hFF, 1'b0, 2'b00);
    chk("mbox1_valid", ev1, 1);
    chk("mbox1_pass", ep1, 1);
    chk("mbox1_code", ec1, 64'h0);
    wr("mbox7_ign", 64'h1000, 8'd0, 3'd3, 2'b01, 64'h7, 8'hFF, 1'b0, 2'b00);
    chk("mbox_hold_valid", ev1, 1);
    chk("mbox_hold_pass", ep1, 1);
    chk("mbox_hold_code", ec1, 64'h0);
    exp_q[0] = 64'h7;
    rd("r1000", 1'b0, 64'h1000, 8'd0, 3'd3, 2'b01, 1'b0, 1, 2'b00);

    // fresh run: failing exit code
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mbox_rst_clear", ev1, 0);
    wr("mbox7", 64'h1000, 8'd0, 3'd3, 2'b01, 64'h7, 8'hFF, 1'b0, 2'b00);
    chk("mbox7_valid", ev1, 1);
    chk("mbox7_pass", ep1, 0);
    chk("mbox7_code", ec1, 64'h3);

    // reset in the middle of a write burst
    awid = 4'h3; awaddr = 64'h500; awlen = 8'd3; awsize = 3'd3; awburst = 2'b01; awvalid = 1'b1;
    #1;
    chk("abort_awready", if1.awready, 1);
    tick();
    awvalid = 1'b0;
    wdata = 64'h7000; wstrb = 8'hFF; wlast = 1'b0; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("abort_bvalid", if1.bvalid, 0);
    chk("abort_awready_after", if1.awready, 1);
    tick();
    chk("abort_bvalid_later", if1.bvalid, 0);
    exp_q[0] = 64'h7000;
    rd("r500_kept", 1'b0, 64'h500, 8'd0, 3'd3, 2'b01, 1'b0, 1, 2'b00);
    exp_q[0] = 64'h1122_3344_5566_7788;
    rd("r40_after_rst", 1'b0, 64'h40, 8'd0, 3'd3, 2'b01, 1'b0, 1, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
